// File: rtl/seq_detect.sv
// rtl/seq_detect.sv - parametrised serial pattern detector (KMP-style fallback tables)
// Optional saturating match counter and count port: define SEQ_DETECT_COUNT_EN.
module seq_detect #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b0110,
  parameter bit                 OVERLAP = 1'b1,
  parameter bit                 REG_OUT = 1'b0,
  parameter int                 CNT_W   = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           in,
  input  logic                           clr,
  output logic                           match,
  output logic [$clog2(PAT_LEN+1)-1:0]   progress
`ifdef SEQ_DETECT_COUNT_EN
  ,
  output logic [CNT_W-1:0]               count
`endif
);

  localparam int KW    = $clog2(PAT_LEN + 1);
  localparam int DEPTH = 1 << KW;

  // Pattern bit i in arrival order (bit 0 is received first).
  function automatic int pat_bit(input int i);
    return int'(PATTERN[PAT_LEN-1-i]);
  endfunction

  // Longest j <= k where the last j bits of (prefix k, then b) equal prefix j.
  function automatic int miss_next(input int k, input int b);
    int r;
    int s;
    bit ok;
    r = 0;
    for (int j = 1; j <= k; j++) begin
      ok = 1'b1;
      for (int i = 0; i < j; i++) begin
        s = (k + 1 - j + i == k) ? b : pat_bit(k + 1 - j + i);
        if (s != pat_bit(i)) ok = 1'b0;
      end
      if (ok) r = j;
    end
    return r;
  endfunction

  function automatic int border();
    int r;
    bit ok;
    r = 0;
    for (int j = 1; j < PAT_LEN; j++) begin
      ok = 1'b1;
      for (int i = 0; i < j; i++)
        if (pat_bit(i) != pat_bit(PAT_LEN - j + i)) ok = 1'b0;
      if (ok) r = j;
    end
    return r;
  endfunction

  localparam logic [KW-1:0] K_AFTER = OVERLAP ? KW'(border()) : '0;

  if (PAT_LEN < 2 || CNT_W < 1) begin : g_bad_param
    $error("seq_detect: PAT_LEN must be >= 2 and CNT_W >= 1");
  end

  logic [DEPTH-1:0] exp_bit;
  logic [KW-1:0]    miss0 [DEPTH];
  logic [KW-1:0]    miss1 [DEPTH];

  // Tables padded to a power of two so k indexes them at full width.
  for (genvar g = 0; g < DEPTH; g++) begin : g_tab
    if (g < PAT_LEN) begin : g_live
      assign exp_bit[g] = PATTERN[PAT_LEN-1-g];
      assign miss0[g]   = KW'(miss_next(g, 0));
      assign miss1[g]   = KW'(miss_next(g, 1));
    end else begin : g_pad
      assign exp_bit[g] = 1'b0;
      assign miss0[g]   = '0;
      assign miss1[g]   = '0;
    end
  end

  logic [KW-1:0] k;
  logic [KW-1:0] k_nxt;
  logic          hit;
  logic          last;
  logic          match_c;

  assign hit     = (in == exp_bit[k]);
  assign last    = (k == KW'(PAT_LEN - 1));
  assign match_c = en & ~clr & hit & last;

  always_comb begin
    k_nxt = k;
    if (clr) begin
      k_nxt = '0;
    end else if (en) begin
      if (!hit)      k_nxt = in ? miss1[k] : miss0[k];
      else if (last) k_nxt = K_AFTER;
      else           k_nxt = k + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) k <= '0;
    else     k <= k_nxt;
  end

  assign progress = k;

  if (REG_OUT) begin : g_reg_out
    logic match_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) match_q <= 1'b0;
      else     match_q <= match_c;
    end
    assign match = match_q;
  end else begin : g_comb_out
    assign match = match_c;
  end

`ifdef SEQ_DETECT_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       count <= '0;
    else if (clr)                  count <= '0;
    else if (match_c && count != '1) count <= count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_seq_detect.sv
// tb/tb_seq_detect.sv - randomized and directed checks of seq_detect against a history model
module tb_seq_detect;

  localparam int         NC       = 6;
  localparam int         LENS [NC] = '{4, 4, 4, 4, 5, 2};
  localparam logic [7:0] PATS [NC] = '{8'h06, 8'h06, 8'h0F, 8'h0F, 8'h15, 8'h03};
  localparam bit         OVS  [NC] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  localparam bit         REGS [NC] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  localparam int         CWS  [NC] = '{8, 8, 8, 8, 8, 2};

  logic clk = 1'b0;
  logic rst, en, in, clr;
  always #5 clk = ~clk;

  logic match_o [NC];
  int   prog_o  [NC];
  int   cnt_o   [NC];

  for (genvar c = 0; c < NC; c++) begin : g_dut
    localparam int           L = LENS[c];
    localparam logic [L-1:0] P = PATS[c][L-1:0];
    logic                      m;
    logic [$clog2(L+1)-1:0]    p;
`ifdef SEQ_DETECT_COUNT_EN
    logic [CWS[c]-1:0]         cnt;
    assign cnt_o[c] = int'(cnt);
`else
    assign cnt_o[c] = 0;
`endif
    seq_detect #(
      .PAT_LEN(L), .PATTERN(P), .OVERLAP(OVS[c]), .REG_OUT(REGS[c]), .CNT_W(CWS[c])
    ) u_dut (
      .clk(clk), .rst(rst), .en(en), .in(in), .clr(clr),
      .match(m), .progress(p)
`ifdef SEQ_DETECT_COUNT_EN
      , .count(cnt)
`endif
    );
    assign match_o[c] = m;
    assign prog_o[c]  = int'(p);
  end

  // Model: last accepted bits (as an integer, newest in LSB) and how many are meaningful.
  int hv [NC];
  int hl [NC];
  int mcnt [NC];
  bit regm [NC];
  int obs [NC];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model_prog(input int c);
    int r = 0;
    int l = LENS[c];
    int p = int'(PATS[c]);
    for (int j = 1; j < l; j++)
      if (j <= hl[c] && (hv[c] & ((1 << j) - 1)) == (p >> (l - j))) r = j;
    return r;
  endfunction

  function automatic bit model_hit(input int c, input bit b);
    int l  = LENS[c];
    int nv = ((hv[c] << 1) | int'(b)) & ((1 << l) - 1);
    int nl = (hl[c] + 1 < l) ? hl[c] + 1 : l;
    return (nl == l) && (nv == int'(PATS[c]));
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      hv[c] = 0; hl[c] = 0; mcnt[c] = 0; regm[c] = 1'b0;
    end
  endtask

  task automatic model_step(input bit e, input bit b, input bit cl);
    bit m;
    int l;
    for (int c = 0; c < NC; c++) begin
      l = LENS[c];
      m = e && !cl && model_hit(c, b);
      if (cl) begin
        hv[c] = 0; hl[c] = 0; mcnt[c] = 0;
      end else if (e) begin
        if (m && !OVS[c]) begin
          hv[c] = 0; hl[c] = 0;
        end else begin
          hv[c] = ((hv[c] << 1) | int'(b)) & ((1 << l) - 1);
          hl[c] = (hl[c] + 1 < l) ? hl[c] + 1 : l;
        end
      end
      if (m && mcnt[c] < (1 << CWS[c]) - 1) mcnt[c]++;
      regm[c] = m;
    end
  endtask

  task automatic cycle(input bit e, input bit b, input bit cl);
    int exp_m;
    en = e; in = b; clr = cl;
    @(negedge clk);
    for (int c = 0; c < NC; c++) begin
      exp_m = REGS[c] ? int'(regm[c]) : int'(e && !cl && model_hit(c, b));
      check($sformatf("match[%0d]", c), int'(match_o[c]), exp_m);
      if (match_o[c]) obs[c]++;
      check($sformatf("progress[%0d]", c), prog_o[c], model_prog(c));
`ifdef SEQ_DETECT_COUNT_EN
      check($sformatf("count[%0d]", c), cnt_o[c], mcnt[c]);
`endif
    end
    @(posedge clk);
    model_step(e, b, cl);
    #1;
  endtask

  task automatic async_reset();
    en = 1'b0; clr = 1'b0;
    #1 rst = 1'b1;
    #1;
    model_reset();
    for (int c = 0; c < NC; c++) begin
      check($sformatf("rst_progress[%0d]", c), prog_o[c], 0);
      check($sformatf("rst_match[%0d]", c), int'(match_o[c]), 0);
`ifdef SEQ_DETECT_COUNT_EN
      check($sformatf("rst_count[%0d]", c), cnt_o[c], 0);
`endif
    end
    #1 rst = 1'b0;
  endtask

  task automatic clear_obs();
    for (int c = 0; c < NC; c++) obs[c] = 0;
  endtask

  task automatic run_bits(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) cycle(1'b1, bits[i], 1'b0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; in = 1'b0; clr = 1'b0;
    model_reset();
    clear_obs();
    @(posedge clk);
    #1;
    for (int c = 0; c < NC; c++) begin
      check($sformatf("init_progress[%0d]", c), prog_o[c], 0);
      check($sformatf("init_match[%0d]", c), int'(match_o[c]), 0);
    end
    rst = 1'b0;

    // 0,1,1,0,1,1,0: overlapping 0110 hits twice, non-overlapping once.
    run_bits(16'b0110110, 7);
    cycle(1'b0, 1'b0, 1'b0);
    check("ovl_0110_pulses", obs[0], 2);
    check("novl_0110_pulses", obs[1], 1);

    // Eight 1s against 1111.
    cycle(1'b1, 1'b0, 1'b1);
    clear_obs();
    run_bits(16'hFF, 8);
    cycle(1'b0, 1'b0, 1'b0);
    check("ovl_1111_pulses", obs[2], 5);
    check("novl_1111_pulses", obs[3], 2);

    // Enable gap holds progress; final bit completes 0110.
    cycle(1'b1, 1'b0, 1'b1);
    clear_obs();
    run_bits(16'b01, 2);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'($urandom), 1'b0);
    run_bits(16'b10, 2);
    check("gap_pulses", obs[0], 1);

    // Same, with clr on the final bit.
    cycle(1'b1, 1'b0, 1'b1);
    clear_obs();
    run_bits(16'b01, 2);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'($urandom), 1'b0);
    run_bits(16'b1, 1);
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0);
    check("clr_final_pulses", obs[0], 0);

    // Reset mid-pattern discards the partial 011.
    run_bits(16'b011, 3);
    async_reset();
    clear_obs();
    run_bits(16'b0, 1);
    check("post_rst_single0", obs[0], 0);
    run_bits(16'b0110, 4);
    check("post_rst_match", obs[0], 1);

    // Pattern 11 with a 2-bit counter saturates after three matches.
    cycle(1'b1, 1'b0, 1'b1);
    clear_obs();
    run_bits(16'b111111, 6);
    check("sat_pulses", obs[5], 5);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) async_reset();
      else cycle(($urandom_range(0, 4) != 0), 1'($urandom), ($urandom_range(0, 39) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
